// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter: FSM states,
// parity-mode codes and the width of the data-bits configuration field.
package uart_pkg;

    localparam int CFG_DBITS_W = 4;
    localparam logic [CFG_DBITS_W-1:0] MIN_DBITS = 4'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam logic [1:0] PAR_NONE  = 2'b00;
    localparam logic [1:0] PAR_EVEN  = 2'b01;
    localparam logic [1:0] PAR_ODD   = 2'b10;
    localparam logic [1:0] PAR_NONE2 = 2'b11;

    // Out-of-range data-bit requests fall back to the full word width.
    function automatic logic [CFG_DBITS_W-1:0] eff_dbits(
        input logic [CFG_DBITS_W-1:0] cfg,
        input logic [CFG_DBITS_W-1:0] max_bits
    );
        if ((cfg < MIN_DBITS) || (cfg > max_bits)) return max_bits;
        return cfg;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Counts oversample ticks and flags the tick that closes a bit period.
module uart_bit_timer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_b_tick,
    output logic o_bit_end
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(OVERSAMPLE - 1);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state always uses non-blocking assignment so every
    // register samples values from before the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_b_tick) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_bit_end = i_b_tick && (r_cnt == LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5..DATA_W data bits, optional parity,
// one or two stop bits; configuration is captured with each accepted word.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   b_tick,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    input  logic [DATA_W-1:0]      d_in,
    input  logic [CFG_DBITS_W-1:0] cfg_dbits,
    input  logic [1:0]             cfg_parity,
    input  logic                   cfg_stop2,
    output logic                   tx_done,
    output logic                   tx_busy,
    output logic                   tx
);

    localparam logic [CFG_DBITS_W-1:0] MAX_DBITS = CFG_DBITS_W'(DATA_W);

    state_t                 r_state, w_state_next;
    logic [DATA_W-1:0]      r_shift, w_shift_next;
    logic [CFG_DBITS_W-1:0] r_bit_cnt, w_bit_cnt_next;
    logic [CFG_DBITS_W-1:0] r_dbits;
    logic                   r_par_en, r_par_bit, r_stop2;
    logic                   r_tx, w_tx_next;
    logic                   w_accept, w_bit_end, w_done, w_data_par;
    logic [CFG_DBITS_W-1:0] w_dbits_eff;

    assign w_accept    = (r_state == ST_IDLE) && tx_valid;
    assign w_dbits_eff = eff_dbits(cfg_dbits, MAX_DBITS);

    uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_clear  (w_accept),
        .i_b_tick (b_tick && (r_state != ST_IDLE)),
        .o_bit_end(w_bit_end)
    );

    // Parity is resolved at acceptance over only the bits that will be sent.
    always_comb begin
        w_data_par = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < int'(w_dbits_eff)) w_data_par = w_data_par ^ d_in[i];
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_tx_next      = r_tx;
        w_done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tx_next = 1'b1;
                if (tx_valid) begin
                    w_state_next   = ST_START;
                    w_shift_next   = d_in;
                    w_bit_cnt_next = '0;
                    w_tx_next      = 1'b0;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_next = ST_DATA;
                    w_tx_next    = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit_cnt == r_dbits - 1'b1) begin
                        w_bit_cnt_next = '0;
                        w_state_next   = r_par_en ? ST_PARITY : ST_STOP;
                        w_tx_next      = r_par_en ? r_par_bit : 1'b1;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                        w_tx_next      = w_shift_next[0];
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = ST_STOP;
                    w_tx_next    = 1'b1;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    if (r_stop2 && (r_bit_cnt == '0)) begin
                        w_bit_cnt_next = 1;
                    end else begin
                        w_done         = 1'b1;
                        w_bit_cnt_next = '0;
                        w_state_next   = ST_IDLE;
                        w_tx_next      = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_tx      <= w_tx_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dbits   <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_stop2   <= 1'b0;
        end else if (w_accept) begin
            r_dbits   <= w_dbits_eff;
            r_par_en  <= (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
            r_par_bit <= (cfg_parity == PAR_ODD) ? ~w_data_par : w_data_par;
            r_stop2   <= cfg_stop2;
        end
    end

    assign tx_ready = (r_state == ST_IDLE);
    assign tx_busy  = ~tx_ready;
    assign tx_done  = w_done;
    assign tx       = r_tx;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: frames are predicted as a list of
// line levels, one per bit period, and compared tick by tick.
module tb_uart_tx_cfg;

    localparam int DW = 8;
    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       b_tick, tx_valid, cfg_stop2;
    logic [7:0] d_in;
    logic [3:0] cfg_dbits;
    logic [1:0] cfg_parity;
    logic       tx_ready, tx_done, tx_busy, tx;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    uart_tx_cfg #(.DATA_W(DW), .OVERSAMPLE(OS)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .b_tick    (b_tick),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .d_in      (d_in),
        .cfg_dbits (cfg_dbits),
        .cfg_parity(cfg_parity),
        .cfg_stop2 (cfg_stop2),
        .tx_done   (tx_done),
        .tx_busy   (tx_busy),
        .tx        (tx)
    );

    always #5 clk = ~clk;

    // Line level for each bit period of a frame, straight from the frame rules.
    function automatic void build_expected(input logic [7:0] data, input logic [3:0] dbits,
                                           input logic [1:0] par, input logic stop2);
        int n;
        bit p;
        exp_q.delete();
        n = (dbits >= 5 && dbits <= DW) ? int'(dbits) : DW;
        p = 1'b0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(data[i]);
            p = p ^ data[i];
        end
        if (par == 2'b01) exp_q.push_back(p);
        else if (par == 2'b10) exp_q.push_back(!p);
        exp_q.push_back(1'b1);
        if (stop2) exp_q.push_back(1'b1);
    endfunction

    task automatic scramble_inputs(input bit hold_valid);
        d_in       = 8'($urandom);
        cfg_dbits  = 4'($urandom);
        cfg_parity = 2'($urandom);
        cfg_stop2  = 1'($urandom);
        tx_valid   = hold_valid;
    endtask

    // Offers a word in the next cycle; checks the block is idle and accepts it.
    task automatic offer(input string name, input logic [7:0] data, input logic [3:0] dbits,
                         input logic [1:0] par, input logic stop2);
        @(negedge clk);
        d_in = data; cfg_dbits = dbits; cfg_parity = par; cfg_stop2 = stop2;
        tx_valid = 1'b1;
        b_tick = 1'($urandom);
        #1;
        checks++;
        if (tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx !== 1'b1 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_before: ready=%b busy=%b tx=%b done=%b, required 1 0 1 0",
                     name, tx_ready, tx_busy, tx, tx_done);
        end
        @(posedge clk);
    endtask

    // Runs one frame to its end, checking line level, status and tx_done each cycle.
    task automatic run_frame(input string name, input logic [7:0] data, input logic [3:0] dbits,
                             input logic [1:0] par, input logic stop2, input bit hold_valid);
        int ticks, total, bit_err, done_err;
        bit exp_done;
        build_expected(data, dbits, par, stop2);
        total = exp_q.size() * OS;
        offer(name, data, dbits, par, stop2);
        ticks = 0; bit_err = 0; done_err = 0;
        for (int cyc = 0; cyc < 4000 && ticks < total; cyc++) begin
            @(negedge clk);
            scramble_inputs(hold_valid);
            b_tick = ($urandom_range(0, 2) != 0);
            #1;
            exp_done = b_tick && (ticks == total - 1);
            if (tx !== exp_q[ticks / OS] || tx_ready !== 1'b0 || tx_busy !== 1'b1) bit_err++;
            if (tx_done !== exp_done) done_err++;
            @(posedge clk);
            if (b_tick) ticks++;
        end
        checks++;
        if (ticks != total) begin
            errors++;
            $display("FAIL %s length: %0d ticks seen, required %0d", name, ticks, total);
        end
        checks++;
        if (bit_err != 0) begin
            errors++;
            $display("FAIL %s line: %0d bad cycles, required 0", name, bit_err);
        end
        checks++;
        if (done_err != 0) begin
            errors++;
            $display("FAIL %s tx_done: %0d bad cycles, required 0", name, done_err);
        end
    endtask

    task automatic idle_watch(input string name, input int cycles);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            b_tick = 1'($urandom);
            #1;
            if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d non-idle cycles, required 0", name, bad);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        b_tick = 1'b0; tx_valid = 1'b0; d_in = '0;
        cfg_dbits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: tx=%b ready=%b busy=%b done=%b, required 1 1 0 0",
                     tx, tx_ready, tx_busy, tx_done);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_reset_mid_frame;
        int ticks;
        build_expected(8'hA5, 4'd8, 2'b00, 1'b0);
        offer("abort", 8'hA5, 4'd8, 2'b00, 1'b0);
        ticks = 0;
        for (int cyc = 0; cyc < 2000 && ticks < 70; cyc++) begin
            @(negedge clk);
            scramble_inputs(1'b0);
            b_tick = 1'($urandom);
            @(posedge clk);
            if (b_tick) ticks++;
        end
        @(negedge clk);
        b_tick = 1'b0;
        #1;
        checks++;
        if (ticks != 70 || tx !== exp_q[ticks / OS]) begin
            errors++;
            $display("FAIL abort_in_data3: ticks=%0d tx=%b, required 70 and %b",
                     ticks, tx, exp_q[4]);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_async: tx=%b ready=%b busy=%b done=%b, required 1 1 0 0",
                     tx, tx_ready, tx_busy, tx_done);
        end
        repeat (2) begin
            @(negedge clk);
            b_tick = 1'b1;
        end
        @(negedge clk);
        reset_n = 1'b1;
        idle_watch("abort_no_done", 40);
    endtask

    initial begin
        test_reset();
        idle_watch("idle_ticks_ignored", 30);
        run_frame("8n1_a5", 8'hA5, 4'd8, 2'b00, 1'b0, 1'b0);
        run_frame("7o2_35", 8'h35, 4'd7, 2'b10, 1'b1, 1'b0);
        run_frame("5n1_ff", 8'hFF, 4'd5, 2'b00, 1'b0, 1'b0);
        run_frame("dbits12_3c", 8'h3C, 4'd12, 2'b00, 1'b0, 1'b0);
        run_frame("dbits3_c6", 8'hC6, 4'd3, 2'b11, 1'b0, 1'b0);
        run_frame("8e1_01", 8'h01, 4'd8, 2'b01, 1'b0, 1'b0);
        run_frame("b2b_00", 8'h00, 4'd8, 2'b00, 1'b0, 1'b1);
        run_frame("b2b_ff", 8'hFF, 4'd8, 2'b00, 1'b0, 1'b1);
        run_frame("b2b_third", 8'h96, 4'd6, 2'b01, 1'b1, 1'b0);
        test_reset_mid_frame();
        run_frame("after_abort", 8'h5A, 4'd8, 2'b10, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            run_frame("random", 8'($urandom), 4'($urandom), 2'($urandom), 1'($urandom),
                      1'($urandom));
        end
        @(negedge clk);
        tx_valid = 1'b0;
        idle_watch("final_idle", 5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
